// File: rtl/irq_pkg.sv
// Shared sizes and vector types for the interrupt request-capture stage.
package irq_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] req_idx_t;

endpackage : irq_pkg

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser for one asynchronous request line.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain_reg[SYNC_STAGES-1];

  initial begin : depth_check
    assert (SYNC_STAGES >= 2 && SYNC_STAGES <= 3)
      else $fatal(1, "sync_ff: SYNC_STAGES must be 2 or 3");
  end

endmodule : sync_ff

// File: rtl/irq_pending_capture.sv
// Request capture: synchronise, detect rising edges, hold sticky pending bits until acked.
// Optional per-line overflow flags are built only when IRQ_OVF_EN is defined.
module irq_pending_capture
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  req_vec_t req_in,
  input  req_vec_t mask,
  input  logic     ack_valid,
  input  req_idx_t ack_idx,
  output req_vec_t pend_out,
  output logic     pend_any,
  output req_vec_t ovf,
  input  logic     ovf_clr
);

  req_vec_t sync_s;
  req_vec_t s_prev_reg;
  req_vec_t edge_det;
  req_vec_t clr;
  req_vec_t pending_reg;
  req_vec_t pending_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_line
      sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (req_in[gi]),
        .q    (sync_s[gi])
      );

      assign clr[gi] = ack_valid && (ack_idx == req_idx_t'(gi));
      // A fresh edge beats a same-cycle ack so the line re-arms instead of being lost.
      assign pending_next[gi] = edge_det[gi] | (pending_reg[gi] & ~clr[gi]);
    end
  endgenerate

  assign edge_det = sync_s & ~s_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_prev_reg  <= '0;
      pending_reg <= '0;
    end else begin
      s_prev_reg  <= sync_s;
      pending_reg <= pending_next;
    end
  end

  // Mask only hides lines from the encoder; capture carries on underneath.
  assign pend_out = pending_reg & ~mask;
  assign pend_any = |pend_out;

`ifdef IRQ_OVF_EN
  req_vec_t ovf_reg;
  req_vec_t ovf_next;

  always_comb begin
    ovf_next = ovf_clr ? '0 : ovf_reg;
    ovf_next = ovf_next | (edge_det & pending_reg & ~clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= '0;
    end else begin
      ovf_reg <= ovf_next;
    end
  end

  assign ovf = ovf_reg;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf            = '0;
`endif

endmodule : irq_pending_capture

// File: tb/tb_irq_pending_capture.sv
// Self-checking bench for irq_pending_capture; honours IRQ_OVF_EN when defined at compile time.
module tb_irq_pending_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       ack_valid;
  logic [2:0] ack_idx;
  logic [7:0] pend_out;
  logic       pend_any;
  logic [7:0] ovf;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;

  irq_pending_capture #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .mask     (mask),
    .ack_valid(ack_valid),
    .ack_idx  (ack_idx),
    .pend_out (pend_out),
    .pend_any (pend_any),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: a line's rising edge is seen two samples late; pending is
  // set by that edge and cleared by a matching ack, set taking precedence.
  logic [7:0] m_pend;
  logic [7:0] m_ovf;
  logic [7:0] hist[$];
  logic [7:0] m_s, m_sp, m_edge, m_clr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0;
      m_ovf  = '0;
      hist   = {};
    end else begin
      m_s    = (hist.size() > 1) ? hist[1] : 8'h00;
      m_sp   = (hist.size() > 2) ? hist[2] : 8'h00;
      m_edge = m_s & ~m_sp;
      m_clr  = ack_valid ? (8'h01 << ack_idx) : 8'h00;
`ifdef IRQ_OVF_EN
      if (ovf_clr) m_ovf = '0;
      m_ovf = m_ovf | (m_edge & m_pend & ~m_clr);
`endif
      m_pend = m_edge | (m_pend & ~m_clr);
      hist.push_front(req_in);
      if (hist.size() > 3) void'(hist.pop_back());
    end
  end

  function automatic int enc_lsb(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack(int idx);
    ack_valid = 1'b1;
    ack_idx   = 3'(idx);
    step();
    ack_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_in = 8'hFF; mask = '0; ack_valid = 0; ack_idx = '0; ovf_clr = 0;
    step(3);
    checks++;
    if (pend_out !== 8'h00 || pend_any !== 1'b0 || ovf !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: pend_out=%h pend_any=%b ovf=%h expected 00/0/00", pend_out, pend_any, ovf);
    end
    rst_n = 1'b1;
    step(2);
    checks++;
    if (pend_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_early: pend_out=%h expected 00 after 2 edges", pend_out);
    end
    step();
    checks++;
    if (pend_out !== 8'hFF || pend_any !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: pend_out=%h pend_any=%b expected ff/1", pend_out, pend_any);
    end
    for (int i = 0; i < 8; i++) ack(i);
    req_in = '0;
    step(2);
    checks++;
    if (pend_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_drain: pend_out=%h expected 00", pend_out);
    end
    $display("test_reset done");
  endtask

  task automatic test_capture_ack();
    req_in = 8'h20; step(3); req_in = '0; step();
    checks++;
    if (pend_out !== 8'h20 || pend_out !== (m_pend & ~mask)) begin
      errors++;
      $display("FAIL capture5: pend_out=%h expected 20 (model %h)", pend_out, m_pend & ~mask);
    end
    ack(5);
    checks++;
    if (pend_out !== 8'h00 || pend_any !== 1'b0) begin
      errors++;
      $display("FAIL ack5: pend_out=%h pend_any=%b expected 00/0", pend_out, pend_any);
    end
    $display("test_capture_ack done");
  endtask

  task automatic test_priority();
    req_in = 8'h42; step(3); req_in = '0; step();
    checks++;
    if (pend_out !== 8'h42 || enc_lsb(pend_out) != 1) begin
      errors++;
      $display("FAIL prio_both: pend_out=%h enc=%0d expected 42/1", pend_out, enc_lsb(pend_out));
    end
    ack(1);
    checks++;
    if (pend_out !== 8'h40 || enc_lsb(pend_out) != 6) begin
      errors++;
      $display("FAIL prio_after_ack1: pend_out=%h enc=%0d expected 40/6", pend_out, enc_lsb(pend_out));
    end
    ack(6);
    checks++;
    if (pend_out !== 8'h00) begin
      errors++;
      $display("FAIL prio_drain: pend_out=%h expected 00", pend_out);
    end
    $display("test_priority done");
  endtask

  task automatic test_mask();
    mask = 8'h08; req_in = 8'h08; step(3); req_in = '0; step();
    checks++;
    if (pend_out !== 8'h00 || pend_any !== 1'b0 || m_pend[3] !== 1'b1) begin
      errors++;
      $display("FAIL mask_hide: pend_out=%h pend_any=%b model_pend=%h expected 00/0 with bit3 held", pend_out, pend_any, m_pend);
    end
    mask = 8'h00;
    #1;
    checks++;
    if (pend_out !== 8'h08 || pend_any !== 1'b1) begin
      errors++;
      $display("FAIL mask_reveal: pend_out=%h pend_any=%b expected 08/1 same cycle", pend_out, pend_any);
    end
    mask = 8'h08;
    ack(3);
    mask = 8'h00;
    #1;
    checks++;
    if (pend_out !== 8'h00) begin
      errors++;
      $display("FAIL mask_ack: pend_out=%h expected 00 after ack on masked bit", pend_out);
    end
    $display("test_mask done");
  endtask

  task automatic test_simultaneous();
    req_in = 8'h04; step(3); req_in = '0; step(2);
    req_in = 8'h04;
    step(2);
    ack(2);
    checks++;
    if (pend_out[2] !== 1'b1 || ovf !== 8'h00) begin
      errors++;
      $display("FAIL set_wins: pend_out=%h ovf=%h expected bit2 set, ovf 00", pend_out, ovf);
    end
    req_in = '0;
    ack(2);
    step();
    checks++;
    if (pend_out !== 8'h00) begin
      errors++;
      $display("FAIL rearm_clear: pend_out=%h expected 00", pend_out);
    end
    req_in = 8'h02; step(3); req_in = '0; step();
    ack(4);
    checks++;
    if (pend_out !== 8'h02) begin
      errors++;
      $display("FAIL ack_nonpending: pend_out=%h expected 02", pend_out);
    end
    ack(1);
    $display("test_simultaneous done");
  endtask

  task automatic test_ovf();
    logic [7:0] exp_ovf;
`ifdef IRQ_OVF_EN
    exp_ovf = 8'h01;
`else
    exp_ovf = 8'h00;
`endif
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    req_in = 8'h01; step(3); req_in = '0; step(2);
    req_in = 8'h01; step(3); req_in = '0; step(2);
    checks++;
    if (ovf !== exp_ovf || pend_out !== 8'h01) begin
      errors++;
      $display("FAIL ovf_set: ovf=%h pend_out=%h expected %h/01", ovf, pend_out, exp_ovf);
    end
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    checks++;
    if (ovf !== 8'h00) begin
      errors++;
      $display("FAIL ovf_clr: ovf=%h expected 00", ovf);
    end
    ack(0);
    $display("test_ovf done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      checks++;
      if (pend_out !== (m_pend & ~mask) || pend_any !== |(m_pend & ~mask) || ovf !== m_ovf) begin
        errors++;
        $display("FAIL random[%0d]: pend_out=%h pend_any=%b ovf=%h expected %h/%b/%h",
                 n, pend_out, pend_any, ovf, m_pend & ~mask, |(m_pend & ~mask), m_ovf);
      end
      if ($urandom_range(0, 3) == 0) req_in = 8'($urandom);
      mask      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ack_valid = 1'($urandom_range(0, 1));
      ack_idx   = 3'($urandom_range(0, 7));
      ovf_clr   = ($urandom_range(0, 15) == 0);
      step();
    end
    ack_valid = 0; ovf_clr = 0; mask = '0;
    $display("test_random done");
  endtask

  task automatic test_midrun_reset();
    req_in = 8'h81; step(3); req_in = '0; step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pend_out !== 8'h00 || ovf !== 8'h00) begin
      errors++;
      $display("FAIL midrun_reset: pend_out=%h ovf=%h expected 00/00", pend_out, ovf);
    end
    step();
    rst_n = 1'b1;
    step(4);
    checks++;
    if (pend_out !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_idle: pend_out=%h expected 00", pend_out);
    end
    $display("test_midrun_reset done");
  endtask

  initial begin
    test_reset();
    test_capture_ack();
    test_priority();
    test_mask();
    test_simultaneous();
    test_ovf();
    test_random();
    test_midrun_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_irq_pending_capture
